fp_normalize_round: RTL

- Post-add/subtract normalizer and rounder for the FP adder datapath, at the opposite end of the mantissa path from the alignment right-shifter.
- Consumes the raw sum/difference together with the round (R) and sticky (S) bits produced during alignment.
- Left-shifts by the leading-zero count, or right-shifts by 1 on carry-out, then adjusts the exponent and rounds to nearest-even.
- Two-stage valid/ready pipeline with full backpressure, throughput 1 result/cycle.

---
 rtl/fp_normalize_round.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// Post-add normalizer and round-to-nearest-even stage for the FP adder datapath.
// Stage 1 normalizes (carry right-shift or leading-zero left-shift); stage 2 rounds and flags.
module fp_normalize_round #(
  parameter int n   = 23,
  parameter int exp = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n+1:0]   in_sum,
  input  logic [exp-1:0] in_exp,
  input  logic           in_sign,
  input  logic           in_r,
  input  logic           in_s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [n-1:0]   out_mant,
  output logic [exp-1:0] out_exp,
  output logic           out_sign,
  output logic           out_zero,
  output logic           out_ovf,
  output logic           out_unf
);

  localparam int LW = $clog2(n + 2);
  localparam logic [exp:0] EMAX = {1'b0, {exp{1'b1}}};

  // Handshake: a beat moves on valid & ready; a stage loads when the next stage
  // is empty or draining this cycle, so the pipe streams one beat per cycle.
  logic           s1_valid;
  logic [n:0]     s1_mant;
  logic           s1_r;
  logic           s1_s;
  logic           s1_sign;
  logic           s1_zero;
  logic           s1_unf;
  logic [exp:0]   s1_e;
  logic           s1_advance;

  assign s1_advance = s1_valid & (~out_valid | out_ready);
  assign in_ready   = rst_n & (~s1_valid | s1_advance);

  logic [LW-1:0]  lzc;
  logic [n+1:0]   shifted;
  logic [exp:0]   lzc_x;
  logic [exp:0]   exp_x;
  logic [n:0]     n_mant;
  logic           n_r;
  logic           n_s;
  logic           n_zero;
  logic           n_unf;
  logic [exp:0]   n_e;

  always_comb begin
    lzc = LW'(n + 1);
    for (int i = 0; i <= n; i++) begin
      if (in_sum[i]) lzc = LW'(n - i);
    end
    shifted = {in_sum[n:0], in_r} << lzc;
    lzc_x   = (exp + 1)'(lzc);
    exp_x   = {1'b0, in_exp};
    n_zero  = (in_sum == '0) & ~in_r & ~in_s;
    if (in_sum[n+1]) begin
      n_mant = in_sum[n+1:1];
      n_r    = in_sum[0];
      n_s    = in_r | in_s;
      n_e    = exp_x + (exp + 1)'(1);
      n_unf  = 1'b0;
    end else begin
      n_mant = shifted[n+1:1];
      n_r    = shifted[0];
      // Sticky only survives a shift of at most one place.
      n_s    = (lzc <= LW'(1)) ? in_s : 1'b0;
      n_e    = exp_x - lzc_x;
      n_unf  = ~n_zero & (lzc_x >= exp_x);
    end
    if (n_zero) n_e = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_unf   <= 1'b0;
      s1_e     <= '0;
    end else if (~s1_valid | s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= n_mant;
        s1_r    <= n_r;
        s1_s    <= n_s;
        s1_sign <= in_sign;
        s1_zero <= n_zero;
        s1_unf  <= n_unf;
        s1_e    <= n_e;
      end
    end
  end

  logic           up;
  logic [n+1:0]   mant2;
  logic [exp:0]   e2;
  logic           r_ovf;

  always_comb begin
    up    = s1_r & (s1_s | s1_mant[0]);
    mant2 = {1'b0, s1_mant} + {{(n + 1){1'b0}}, up};
    // A rounding carry leaves mant2 = 1.000..0, so the fraction bits are already zero.
    e2    = s1_e + {{exp{1'b0}}, mant2[n+1]};
    r_ovf = (e2 >= EMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      if (~out_valid | out_ready) out_valid <= s1_valid;
      if (s1_advance) begin
        out_sign <= s1_sign;
        out_zero <= s1_zero | s1_unf;
        out_unf  <= s1_unf;
        out_ovf  <= ~s1_zero & ~s1_unf & r_ovf;
        if (s1_zero | s1_unf) begin
          out_exp  <= '0;
          out_mant <= '0;
        end else if (r_ovf) begin
          out_exp  <= '1;
          out_mant <= '0;
        end else begin
          out_exp  <= e2[exp-1:0];
          out_mant <= mant2[n-1:0];
        end
      end
    end
  end

endmodule
